fifo_burst_drain_ctrl: RTL and testbench

- Read-side sequencer for the sweep-sample FIFO. Watches the FIFO fill count and drains it in fixed-length bursts.
- Drained words go to a downstream consumer (DAC/UART packetiser) over a valid/ready stream, with `m_last` marking the final word of each burst.
- Optional timeout flush drains a partial burst when data sits too long.
- Sits between the FIFO read port and the consumer. It is the only driver of the FIFO `rd_en`.

---
 rtl/fifo_burst_drain_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fifo_burst_drain_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain_ctrl.sv
// Read-side burst sequencer: drains a FIFO in fixed bursts onto a valid/ready stream.
// Define FIFO_DRAIN_TIMEOUT_FLUSH_EN to flush partial bursts after TIMEOUT idle cycles.
module fifo_burst_drain_ctrl #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic [15:0]      bursts_done,
    output logic [1:0]       dbg_state
);

    // Stream handshake: a word transfers in any cycle with m_valid & m_ready; once
    // m_valid is high it stays high with m_data/m_last stable until that transfer.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    state_t           state, state_next;
    logic [CNT_W-1:0] beats, beats_next;
    logic             rd_en;
    logic             inflight, inflight_last;
    logic [WIDTH-1:0] head_data, tail_data;
    logic             head_last, tail_last;
    logic [1:0]       occ;
    logic             pop, push, credit_ok;
    logic             flush_hit;

    assign m_valid    = (occ != 2'd0);
    assign m_data     = head_data;
    assign m_last     = m_valid & head_last;
    assign pop        = m_valid & m_ready;
    assign push       = inflight;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign fifo_rd_en = rd_en & ~reset;

    // Words already requested count against the two buffer slots, so the skid never overflows.
    assign credit_ok = (({1'b0, occ} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;

`ifdef FIFO_DRAIN_TIMEOUT_FLUSH_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_qual;

    assign to_qual   = (state == IDLE) && enable && !fifo_empty && (fifo_count < BURST_LEN_C);
    assign flush_hit = to_qual && (to_cnt == TO_LAST) && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (to_qual && !flush_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign flush_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        beats_next = beats;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (fifo_count >= BURST_LEN_C)) begin
                    state_next = BURST;
                    beats_next = BURST_LEN_C;
                end else if (flush_hit) begin
                    state_next = BURST;
                    beats_next = fifo_count;
                end
            end
            BURST: begin
                if (!fifo_empty && credit_ok && (beats != '0)) begin
                    rd_en      = 1'b1;
                    beats_next = beats - 1'b1;
                    if (beats == CNT_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beats         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            bursts_done   <= '0;
        end else begin
            state         <= state_next;
            beats         <= beats_next;
            inflight      <= rd_en;
            inflight_last <= rd_en && (beats == CNT_W'(1));
            if ((state == DRAIN) && pop && m_last) begin
                bursts_done <= bursts_done + 16'd1;
            end
        end
    end

    // Two-entry ordered skid buffer; head always drives the stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ       <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= fifo_dout;
                        head_last <= inflight_last;
                    end else begin
                        tail_data <= fifo_dout;
                        tail_last <= inflight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= fifo_dout;
                        head_last <= inflight_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= fifo_dout;
                        tail_last <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// Directed bench for fifo_burst_drain_ctrl: behavioural FIFO, stream scoreboard, protocol checks.
module tb_fifo_burst_drain_ctrl;

    localparam int WIDTH      = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int BURST_LEN  = 8;
    localparam int TIMEOUT    = 64;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic [15:0]      bursts_done;
    logic [1:0]       dbg_state;

    fifo_burst_drain_ctrl #(
        .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .bursts_done(bursts_done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];

    int n_checks, n_pass;
    int cyc, rd_cnt, acc_cnt, v_cnt, last_cnt;
    int first_rd, last_rd, first_v, last_v, max_out, acc_in_burst, burst_len;
    logic             hold_pend;
    logic [WIDTH-1:0] hold_data;
    logic             ready_mode;
    logic             force_empty;
    int               saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic update_fifo_flags();
        fifo_count = CNT_W'(fifo_q.size());
        fifo_empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic fill(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + WIDTH'(i));
            exp_q.push_back(base + WIDTH'(i));
        end
        update_fifo_flags();
    endtask

    task automatic clear_mon();
        rd_cnt = 0; acc_cnt = 0; v_cnt = 0; last_cnt = 0;
        first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
        max_out = 0; acc_in_burst = 0; hold_pend = 1'b0; cyc = 0;
    endtask

    // One clock: monitor + scoreboard at the falling edge, FIFO model update after the rising edge.
    task automatic tick();
        logic             rd_seen;
        logic [WIDTH-1:0] exp_w;
        logic             exp_last;
        @(negedge clk);
        rd_seen = fifo_rd_en;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
            end
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (m_valid) begin
                v_cnt++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (m_valid && m_ready) begin
                acc_cnt++;
                if (m_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_word", m_data, 32'hDEAD);
                end else begin
                    exp_w    = exp_q.pop_front();
                    exp_last = (acc_in_burst == burst_len - 1);
                    check("data", m_data, exp_w);
                    check("last", m_last, exp_last);
                    acc_in_burst = exp_last ? 0 : acc_in_burst + 1;
                end
            end
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
            if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen) begin
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else check("rd_on_empty", 1, 0);
        end
        update_fifo_flags();
        if (ready_mode) m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; m_ready = 1'b0; ready_mode = 1'b0; force_empty = 1'b0;
        fifo_q.delete(); exp_q.delete();
        update_fifo_flags();
        tick(); tick();
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, dbg_state, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_bursts"}, bursts_done, 0);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; fifo_dout = '0; burst_len = BURST_LEN;
        reset = 1'b1; enable = 1'b0; m_ready = 1'b0; ready_mode = 1'b0; force_empty = 1'b0;
        update_fifo_flags();
        clear_mon();

        // Reset values and a clean full burst with m_ready held high.
        do_reset();
        check_idle_outputs("rst");
        fill(8, 8'hA0);
        enable = 1'b1; m_ready = 1'b1;
        repeat (30) tick();
        check("t1_rd_cnt", rd_cnt, 8);
        check("t1_rd_span", last_rd - first_rd + 1, 8);
        check("t1_latency", first_v - first_rd, 2);
        check("t1_valid_cnt", v_cnt, 8);
        check("t1_valid_span", last_v - first_v + 1, 8);
        check("t1_last_cnt", last_cnt, 1);
        check("t1_bursts", bursts_done, 1);
        check("t1_busy", busy, 0);
        check("t1_left", exp_q.size(), 0);

        // Back-pressure with m_ready toggling 1,0,0,1.
        do_reset();
        fill(8, 8'h50);
        enable = 1'b1; ready_mode = 1'b1; m_ready = 1'b1;
        repeat (40) tick();
        ready_mode = 1'b0;
        check("t2_acc_cnt", acc_cnt, 8);
        check("t2_rd_cnt", rd_cnt, 8);
        check("t2_outstanding_le2", max_out <= 2, 1);
        check("t2_last_cnt", last_cnt, 1);
        check("t2_bursts", bursts_done, 1);

`ifdef FIFO_DRAIN_TIMEOUT_FLUSH_EN
        // Partial FIFO content flushed after TIMEOUT qualifying idle cycles.
        do_reset();
        fill(3, 8'h30);
        burst_len = 3;
        enable = 1'b1; m_ready = 1'b1;
        repeat (90) tick();
        check("t3_first_rd", first_rd, TIMEOUT);
        check("t3_rd_cnt", rd_cnt, 3);
        check("t3_acc_cnt", acc_cnt, 3);
        check("t3_last_cnt", last_cnt, 1);
        check("t3_bursts", bursts_done, 1);
        burst_len = BURST_LEN;
`else
        // Partial FIFO content never drained without the flush feature.
        do_reset();
        fill(5, 8'h30);
        enable = 1'b1; m_ready = 1'b1;
        repeat (200) tick();
        check("t3_rd_cnt", rd_cnt, 0);
        check("t3_state", dbg_state, 0);
        check("t3_busy", busy, 0);
        check("t3_count", fifo_count, 5);
`endif

        // fifo_empty disturbance mid-burst stalls issue without losing beats.
        do_reset();
        fill(8, 8'h70);
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20 && rd_cnt < 3; i++) tick();
        check("t4_reach_rd3", rd_cnt, 3);
        force_empty = 1'b1;
        update_fifo_flags();
        saved = rd_cnt;
        repeat (3) tick();
        check("t4_stall", rd_cnt, saved);
        force_empty = 1'b0;
        update_fifo_flags();
        repeat (30) tick();
        check("t4_rd_cnt", rd_cnt, 8);
        check("t4_acc_cnt", acc_cnt, 8);
        check("t4_bursts", bursts_done, 1);

        // enable dropped two strobes into a burst; burst completes, no new one starts.
        do_reset();
        fill(16, 8'h10);
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20 && rd_cnt < 2; i++) tick();
        enable = 1'b0;
        repeat (40) tick();
        check("t5_acc_cnt", acc_cnt, 8);
        check("t5_rd_cnt", rd_cnt, 8);
        check("t5_bursts", bursts_done, 1);
        check("t5_state", dbg_state, 0);
        check("t5_count", fifo_count, 8);

        // Reset one cycle after the 4th strobe of the next burst, then a clean restart.
        fill(8, 8'hC0);
        clear_mon();
        enable = 1'b1;
        for (int i = 0; i < 20 && rd_cnt < 4; i++) tick();
        check("t6_reach_rd4", rd_cnt, 4);
        reset = 1'b1; m_ready = 1'b0;
        tick();
        check_idle_outputs("t6_rst");
        reset = 1'b0; m_ready = 1'b1;
        exp_q = fifo_q;
        clear_mon();
        repeat (30) tick();
        check("t6_rd_cnt", rd_cnt, 8);
        check("t6_acc_cnt", acc_cnt, 8);
        check("t6_last_cnt", last_cnt, 1);
        check("t6_bursts", bursts_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
